// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-to-1 word multiplexer with a valid/ready request
// port and a valid/ready output port. Direct mode returns one channel per
// request; scan mode streams Count+1 consecutive channels with wrap-around.
module mux_scan_sel #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]          OpCode,
    input  logic [SEL_W-1:0]          Count,
    input  logic                      Mode,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic [WIDTH-1:0]          Y,
    output logic                      Y_valid,
    input  logic                      Y_ready,
    output logic [SEL_W-1:0]          Ch,
    output logic                      Err,
    output logic                      Last,
    output logic                      Busy
);

    // One extra bit so CHANNELS == 2**SEL_W is representable as the bound.
    localparam logic [SEL_W:0]   CH_LIM = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_MAX = SEL_W'(CHANNELS-1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] rem;
    logic [SEL_W-1:0] rem_nxt;
    logic             slot_free;
    logic             accept;
    logic             load_en;
    logic             load_last;
    logic [SEL_W-1:0] load_ch;

    // Channel index addresses a real input.
    function automatic logic in_range(input logic [SEL_W-1:0] c);
        return {1'b0, c} < CH_LIM;
    endfunction

    // Scan successor with wrap from the last channel back to channel 0.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
        return (c == CH_MAX) ? '0 : c + 1'b1;
    endfunction

    // Word of channel c; out-of-range indices match no channel and give zero.
    function automatic logic [WIDTH-1:0] word_at(input logic [CHANNELS*WIDTH-1:0] bus,
                                                 input logic [SEL_W-1:0]          c);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (c == SEL_W'(k)) begin
                w = bus[k*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    // The output register can take a new beat when empty or being drained.
    assign slot_free = !Y_valid || Y_ready;
    assign req_ready = rst_n && (state == IDLE) && slot_free;
    assign accept    = req_valid && req_ready;
    assign Busy      = (state == SCAN);

    // Next-state logic: decide whether a beat is loaded and from which channel.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        load_en   = 1'b0;
        load_ch   = ptr;
        load_last = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                    load_ch = OpCode;
                    // A bad start channel in scan mode collapses to one error beat.
                    if (!Mode || !in_range(OpCode) || (Count == '0)) begin
                        load_last = 1'b1;
                    end else begin
                        ptr_nxt   = next_ch(OpCode);
                        rem_nxt   = Count;
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                // rem counts beats still to load; the one at rem == 1 is final.
                if (slot_free) begin
                    load_en = 1'b1;
                    load_ch = ptr;
                    ptr_nxt = next_ch(ptr);
                    rem_nxt = rem - 1'b1;
                    if (rem == SEL_W'(1)) begin
                        load_last = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state: FSM state, scan pointer and remaining-beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            rem   <= rem_nxt;
        end
    end

    // Output beat register: load a new beat, retire an accepted one, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y       <= '0;
            Y_valid <= 1'b0;
            Ch      <= '0;
            Err     <= 1'b0;
            Last    <= 1'b0;
        end else if (load_en) begin
            Y       <= word_at(I, load_ch);
            Err     <= !in_range(load_ch);
            Ch      <= load_ch;
            Last    <= load_last;
            Y_valid <= 1'b1;
        end else if (Y_ready) begin
            Y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: two instances (32 and 20 channels, 8-bit words)
// share one stimulus stream and are compared every cycle against a queue-based
// beat model, plus directed sequences with literal expected beats.
module tb_mux_scan_sel;

    localparam int W  = 8;
    localparam int SW = 5;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [32*W-1:0] I_bus;
    logic [SW-1:0]   op;
    logic [SW-1:0]   cnt;
    logic            mode;
    logic            req_valid;
    logic            y_ready;

    logic            rr_a, yv_a, err_a, last_a, busy_a;
    logic [W-1:0]    y_a;
    logic [SW-1:0]   ch_a;
    logic            rr_b, yv_b, err_b, last_b, busy_b;
    logic [W-1:0]    y_b;
    logic [SW-1:0]   ch_b;

    always #5 clk = ~clk;

    mux_scan_sel #(.WIDTH(W), .CHANNELS(32), .SEL_W(SW)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .I(I_bus), .OpCode(op), .Count(cnt), .Mode(mode),
        .req_valid(req_valid), .req_ready(rr_a), .Y(y_a), .Y_valid(yv_a),
        .Y_ready(y_ready), .Ch(ch_a), .Err(err_a), .Last(last_a), .Busy(busy_a));

    mux_scan_sel #(.WIDTH(W), .CHANNELS(20), .SEL_W(SW)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .I(I_bus[20*W-1:0]), .OpCode(op), .Count(cnt), .Mode(mode),
        .req_valid(req_valid), .req_ready(rr_b), .Y(y_b), .Y_valid(yv_b),
        .Y_ready(y_ready), .Ch(ch_b), .Err(err_b), .Last(last_b), .Busy(busy_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: current beat + list of pending channels
    logic         mv[2];
    logic [W-1:0] my[2];
    int           mc[2];
    logic         me[2];
    logic         ml[2];
    int           lst[2][64];
    int           llen[2];
    int           lidx[2];

    task automatic mclear();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; my[i] = '0; mc[i] = 0; me[i] = 1'b0; ml[i] = 1'b0;
            llen[i] = 0; lidx[i] = 0;
        end
    endtask

    task automatic mload(input int i, input int nch, input int c, input logic last);
        mv[i] = 1'b1;
        mc[i] = c;
        me[i] = (c >= nch);
        my[i] = (c < nch) ? I_bus[c*W +: W] : '0;
        ml[i] = last;
    endtask

    task automatic mstep(input int i, input int nch);
        int c;
        if (!mv[i] || y_ready) begin
            if (lidx[i] < llen[i]) begin
                c = lst[i][lidx[i]];
                lidx[i]++;
                mload(i, nch, c, lidx[i] == llen[i]);
            end else if (req_valid) begin
                if (!mode || int'(op) >= nch) begin
                    lst[i][0] = int'(op);
                    llen[i]   = 1;
                end else begin
                    llen[i] = int'(cnt) + 1;
                    for (int j = 0; j < llen[i]; j++) lst[i][j] = (int'(op) + j) % nch;
                end
                lidx[i] = 1;
                mload(i, nch, lst[i][0], llen[i] == 1);
            end else begin
                mv[i] = 1'b0;
            end
        end
    endtask

    function automatic logic mready(input int i);
        return rst_n && (lidx[i] >= llen[i]) && (!mv[i] || y_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclear();
        end else begin
            mstep(0, 32);
            mstep(1, 20);
        end
    end

    // ---------------- per-cycle compare
    task automatic cmp(input int i, input string n, input logic rr, input logic yv,
                       input logic [W-1:0] y, input logic [SW-1:0] ch,
                       input logic err, input logic last, input logic busy);
        check({n, ".req_ready"}, rr, mready(i));
        check({n, ".Y_valid"}, yv, mv[i]);
        check({n, ".Busy"}, busy, lidx[i] < llen[i]);
        if (mv[i] || !rst_n) begin
            check({n, ".Y"}, y, my[i]);
            check({n, ".Ch"}, ch, mc[i]);
            check({n, ".Err"}, err, me[i]);
            check({n, ".Last"}, last, ml[i]);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, "ch32", rr_a, yv_a, y_a, ch_a, err_a, last_a, busy_a);
        cmp(1, "ch20", rr_b, yv_b, y_b, ch_b, err_b, last_b, busy_b);
    end

    // ---------------- beat capture for the directed sequences
    typedef struct {
        int           ch;
        logic [W-1:0] y;
        logic         err;
        logic         last;
        int           cyc;
    } beat_t;

    beat_t cap_a[$];
    beat_t cap_b[$];
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && y_ready) begin
            if (yv_a) cap_a.push_back('{int'(ch_a), y_a, err_a, last_a, cyc});
            if (yv_b) cap_b.push_back('{int'(ch_b), y_b, err_b, last_b, cyc});
        end
    end

    // ---------------- stimulus helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_pattern();
        for (int k = 0; k < 32; k++) I_bus[k*W +: W] = 8'(k + 8'h40);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        y_ready   = 1'b1;
        tick(40);
        cap_a.delete();
        cap_b.delete();
    endtask

    task automatic send(input logic m, input int o, input int c);
        bit got;
        mode      = m;
        op        = SW'(o);
        cnt       = SW'(c);
        req_valid = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = rr_a;
        end
        check("send.accept", got, 1'b1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic check_beats(input string n, input int chs[4], input logic [W-1:0] ys[4]);
        check({n, ".count"}, cap_a.size(), 4);
        if (cap_a.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s.ch%0d", n, k), cap_a[k].ch, chs[k]);
                check($sformatf("%s.y%0d", n, k), cap_a[k].y, ys[k]);
                check($sformatf("%s.last%0d", n, k), cap_a[k].last, k == 3);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] hold_y;
        logic [SW-1:0] hold_ch;
        bit            seen;

        set_pattern();
        op = '0; cnt = '0; mode = 1'b0; req_valid = 1'b0; y_ready = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("rst.Y_valid", yv_a, 1'b0);
        check("rst.Y", y_a, 8'h00);
        check("rst.Busy", busy_a, 1'b0);
        check("rst.req_ready32", rr_a, 1'b0);
        check("rst.req_ready20", rr_b, 1'b0);
        rst_n = 1'b1;
        tick(1);
        check("rel.req_ready32", rr_a, 1'b1);
        check("rel.req_ready20", rr_b, 1'b1);

        // back-to-back direct requests 0, 5, 31
        drain();
        mode = 1'b0; op = 5'd0; req_valid = 1'b1;
        tick(1);
        op = 5'd5;
        tick(1);
        op = 5'd31;
        tick(1);
        req_valid = 1'b0;
        tick(3);
        check("dir.count", cap_a.size(), 3);
        if (cap_a.size() >= 3) begin
            check("dir.y0", cap_a[0].y, 8'h40);
            check("dir.y1", cap_a[1].y, 8'h45);
            check("dir.y2", cap_a[2].y, 8'h5F);
            check("dir.ch2", cap_a[2].ch, 31);
            check("dir.last", {cap_a[0].last, cap_a[1].last, cap_a[2].last}, 3'b111);
            check("dir.gap", cap_a[2].cyc - cap_a[0].cyc, 2);
        end
        check("dir20.count", cap_b.size(), 3);
        if (cap_b.size() >= 3) check("dir20.err2", {cap_b[2].err, cap_b[2].y}, 9'h100);

        // scan with wrap 30,31,0,1
        drain();
        send(1'b1, 30, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("scan.busy", busy_a, 1'b1);
            check("scan.req_ready", rr_a, 1'b0);
        end
        @(negedge clk);
        check("scan.busy_end", busy_a, 1'b0);
        tick(3);
        check_beats("wrap", '{30, 31, 0, 1}, '{8'h5E, 8'h5F, 8'h40, 8'h41});

        // backpressure during a scan while inputs churn
        drain();
        send(1'b1, 2, 3);
        y_ready = 1'b0;
        hold_y  = y_a;
        hold_ch = ch_a;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) I_bus[j*32 +: 32] = $urandom;
            tick(1);
            check("bp.Y_hold", y_a, hold_y);
            check("bp.Ch_hold", ch_a, hold_ch);
        end
        set_pattern();
        y_ready = 1'b1;
        tick(6);
        check_beats("bp", '{2, 3, 4, 5}, '{8'h42, 8'h43, 8'h44, 8'h45});

        // out-of-range channels on the 20-channel instance
        drain();
        send(1'b0, 25, 0);
        tick(3);
        check("oor.d.count", cap_b.size(), 1);
        if (cap_b.size() >= 1)
            check("oor.d.beat", {cap_b[0].err, cap_b[0].last, cap_b[0].y}, 10'h300);
        drain();
        send(1'b1, 22, 4);
        tick(8);
        check("oor.s.count", cap_b.size(), 1);
        if (cap_b.size() >= 1)
            check("oor.s.beat", {cap_b[0].err, cap_b[0].last, cap_b[0].y, 3'b000, cap_b[0].ch[4:0]},
                  {2'b11, 8'h00, 8'd22});
        check("oor.s.count32", cap_a.size(), 5);

        // reset in the middle of a scan
        drain();
        send(1'b1, 0, 10);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (cap_a.size() >= 3);
        end
        check("rscan.three_beats", seen, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rscan.outs", {yv_a, y_a, ch_a, err_a, last_a, busy_a, rr_a}, '0);
        tick(2);
        check("rscan.quiet", yv_a, 1'b0);
        rst_n = 1'b1;
        tick(1);
        cap_a.delete();
        send(1'b0, 7, 0);
        tick(2);
        check("rscan.new.count", cap_a.size() >= 1, 1'b1);
        if (cap_a.size() >= 1) check("rscan.new.y", cap_a[0].y, 8'h47);

        // randomized traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < 8; j++) I_bus[j*32 +: 32] = $urandom;
            req_valid = ($urandom % 3) != 0;
            mode      = 1'($urandom % 2);
            op        = SW'($urandom % 32);
            cnt       = (($urandom % 4) == 0) ? SW'($urandom % 32) : SW'($urandom % 4);
            y_ready   = ($urandom % 4) != 0;
            rst_n     = (($urandom % 500) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
